// File: rtl/traffic_light_monitor_if.sv
// Lamp-bus monitor interface: observed lamp pattern, tick strobe and error clear
// toward the monitor, and decoded phase, timing and error status back out.
interface traffic_light_monitor_if;
    logic       Tick;
    logic [4:0] LED;
    logic       Err_Clr;
    logic [2:0] Phase;
    logic [5:0] Dwell;
    logic       Seq_Err;
    logic       Time_Err;
    logic [1:0] Err_Code;
    logic       Cycle_Done;
    logic [7:0] Cycle_Cnt;

    modport master (
        output Tick, LED, Err_Clr,
        input  Phase, Dwell, Seq_Err, Time_Err, Err_Code, Cycle_Done, Cycle_Cnt
    );

    modport slave (
        input  Tick, LED, Err_Clr,
        output Phase, Dwell, Seq_Err, Time_Err, Err_Code, Cycle_Done, Cycle_Cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light lamp bus: decodes the phase, times
// each phase in ticks, flags sequence/timing errors and counts completed cycles.
module traffic_light_monitor #(
    parameter int unsigned MIN_GO     = 3,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MAX_YELLOW = 3,
    parameter int unsigned MAX_RED    = 20
) (
    input  logic                    CLK_50MHz,
    input  logic                    Res,
    traffic_light_monitor_if.slave  bus
);

    localparam int unsigned DWELL_W = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CODE_W  = 2;
    localparam logic [DWELL_W-1:0] DWELL_SAT = '1;

    localparam logic [CODE_W-1:0] CODE_NONE  = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_SEQ   = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_SHORT = CODE_W'(2);
    localparam logic [CODE_W-1:0] CODE_LONG  = CODE_W'(3);

    typedef enum logic [2:0] {
        DARK      = 3'd0,
        GREEN     = 3'd1,
        ARROW     = 3'd2,
        YELLOW    = 3'd3,
        RED       = 3'd4,
        RED_ARROW = 3'd5,
        ILLEGAL   = 3'd7
    } phase_t;

    phase_t               phase_q, phase_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 seq_err_q, seq_err_d;
    logic                 time_err_q, time_err_d;
    logic [CODE_W-1:0]    err_code_q, err_code_d;
    logic                 cycle_done_q, cycle_done_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;

    phase_t               led_phase;
    logic                 changed;
    logic                 legal_move;
    logic                 seq_ev;
    logic                 short_ev;
    logic                 long_ev;
    logic [CODE_W-1:0]    code_base;

    // Exact-match decode of the lamp pattern
    always_comb begin
        case (bus.LED)
            5'b00000: led_phase = DARK;
            5'b00011: led_phase = GREEN;
            5'b00100: led_phase = ARROW;
            5'b01000: led_phase = YELLOW;
            5'b10000: led_phase = RED;
            5'b10100: led_phase = RED_ARROW;
            default:  led_phase = ILLEGAL;
        endcase
    end

    // Phase register plus all monitor state
    always_ff @(posedge CLK_50MHz) begin
        if (Res) begin
            phase_q      <= DARK;
            dwell_q      <= '0;
            seq_err_q    <= 1'b0;
            time_err_q   <= 1'b0;
            err_code_q   <= CODE_NONE;
            cycle_done_q <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            phase_q      <= phase_d;
            dwell_q      <= dwell_d;
            seq_err_q    <= seq_err_d;
            time_err_q   <= time_err_d;
            err_code_q   <= err_code_d;
            cycle_done_q <= cycle_done_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    // Next phase, transition legality, dwell timing and error bookkeeping
    always_comb begin
        phase_d      = led_phase;
        dwell_d      = dwell_q;
        seq_err_d    = seq_err_q;
        time_err_d   = time_err_q;
        err_code_d   = err_code_q;
        cycle_done_d = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;
        changed      = (led_phase != phase_q);
        legal_move   = 1'b0;
        seq_ev       = 1'b0;
        short_ev     = 1'b0;
        long_ev      = 1'b0;
        code_base    = err_code_q;

        if (led_phase == DARK) begin
            legal_move = 1'b1;
        end else if (led_phase != ILLEGAL) begin
            case (phase_q)
                DARK:         legal_move = 1'b1;
                RED:          legal_move = (led_phase == GREEN) || (led_phase == ARROW);
                GREEN, ARROW: legal_move = (led_phase == YELLOW);
                YELLOW:       legal_move = (led_phase == RED) || (led_phase == RED_ARROW);
                RED_ARROW:    legal_move = (led_phase == RED);
                default:      legal_move = 1'b0;
            endcase
        end

        seq_ev = changed && !legal_move;

        if (changed) begin
            if (((phase_q == GREEN) || (phase_q == ARROW)) && (dwell_q < DWELL_W'(MIN_GO)))
                short_ev = 1'b1;
            if ((phase_q == YELLOW) && (dwell_q < DWELL_W'(MIN_YELLOW)))
                short_ev = 1'b1;
            if ((phase_q == YELLOW) && (dwell_q > DWELL_W'(MAX_YELLOW)))
                long_ev = 1'b1;
        end else if ((phase_q == RED) && bus.Tick && (dwell_q == DWELL_W'(MAX_RED))) begin
            // Dwell only passes MAX_RED once per RED visit, so this fires once
            long_ev = 1'b1;
        end

        // A fresh error in the clearing clock still lands
        if (bus.Err_Clr) begin
            seq_err_d  = 1'b0;
            time_err_d = 1'b0;
            code_base  = CODE_NONE;
        end
        err_code_d = code_base;
        if (seq_ev)
            seq_err_d = 1'b1;
        if (short_ev || long_ev)
            time_err_d = 1'b1;
        if (code_base == CODE_NONE) begin
            if (seq_ev)
                err_code_d = CODE_SEQ;
            else if (short_ev)
                err_code_d = CODE_SHORT;
            else if (long_ev)
                err_code_d = CODE_LONG;
        end

        if (changed)
            dwell_d = '0;
        else if (bus.Tick && (dwell_q != DWELL_SAT))
            dwell_d = dwell_q + DWELL_W'(1);

        cycle_done_d = changed && (phase_q == RED) &&
                       ((led_phase == GREEN) || (led_phase == ARROW));
        cycle_cnt_d  = cycle_cnt_q + CNT_W'(cycle_done_d);
    end

    assign bus.Phase      = phase_q;
    assign bus.Dwell      = dwell_q;
    assign bus.Seq_Err    = seq_err_q;
    assign bus.Time_Err   = time_err_q;
    assign bus.Err_Code   = err_code_q;
    assign bus.Cycle_Done = cycle_done_q;
    assign bus.Cycle_Cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp
// sequences checked against a phase-level behavioural model.
module tb_traffic_light_monitor;

    localparam int MIN_GO     = 3;
    localparam int MIN_YELLOW = 2;
    localparam int MAX_YELLOW = 3;
    localparam int MAX_RED    = 20;

    localparam logic [4:0] P_DARK   = 5'b00000;
    localparam logic [4:0] P_GREEN  = 5'b00011;
    localparam logic [4:0] P_ARROW  = 5'b00100;
    localparam logic [4:0] P_YELLOW = 5'b01000;
    localparam logic [4:0] P_RED    = 5'b10000;
    localparam logic [4:0] P_RARROW = 5'b10100;

    logic CLK_50MHz = 1'b0;
    logic Res = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int m_phase, m_dwell, m_code, m_cnt;
    bit m_seq, m_time, m_done;

    traffic_light_monitor_if bus ();

    traffic_light_monitor dut (
        .CLK_50MHz (CLK_50MHz),
        .Res       (Res),
        .bus       (bus)
    );

    always #10 CLK_50MHz = ~CLK_50MHz;

    function automatic int decode(input logic [4:0] led);
        case (led)
            P_DARK:   return 0;
            P_GREEN:  return 1;
            P_ARROW:  return 2;
            P_YELLOW: return 3;
            P_RED:    return 4;
            P_RARROW: return 5;
            default:  return 7;
        endcase
    endfunction

    function automatic bit allowed(input int from, input int to);
        if (to == 0) return 1'b1;
        if (to == 7) return 1'b0;
        if (from == 0) return 1'b1;
        return (from == 4 && (to == 1 || to == 2)) || ((from == 1 || from == 2) && to == 3) ||
               (from == 3 && (to == 4 || to == 5)) || (from == 5 && to == 4);
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus.Phase, bus.Dwell, bus.Seq_Err, bus.Time_Err, bus.Err_Code,
                bus.Cycle_Done, bus.Cycle_Cnt};
    endfunction

    function automatic logic [21:0] mdl_vec();
        return {3'(m_phase), 6'(m_dwell), m_seq, m_time, 2'(m_code), m_done, 8'(m_cnt)};
    endfunction

    // One clock of the reference model, in terms of phases and tick counts
    task automatic m_step(input logic res, input logic [4:0] led, input logic tick,
                          input logic clr);
        int np;
        bit chg, sev, shrt, lng;
        if (res) begin
            m_phase = 0; m_dwell = 0; m_seq = 0; m_time = 0;
            m_code = 0; m_done = 0; m_cnt = 0;
            return;
        end
        np   = decode(led);
        chg  = (np != m_phase);
        sev  = chg && !allowed(m_phase, np);
        shrt = chg && (((m_phase == 1 || m_phase == 2) && m_dwell < MIN_GO) ||
                       (m_phase == 3 && m_dwell < MIN_YELLOW));
        lng  = (chg && m_phase == 3 && m_dwell > MAX_YELLOW) ||
               (!chg && m_phase == 4 && tick && m_dwell + 1 == MAX_RED + 1);
        if (clr) begin
            m_seq = 0; m_time = 0; m_code = 0;
        end
        if (sev) m_seq = 1;
        if (shrt || lng) m_time = 1;
        if (m_code == 0) m_code = sev ? 1 : shrt ? 2 : lng ? 3 : 0;
        m_done  = chg && m_phase == 4 && (np == 1 || np == 2);
        m_cnt   = (m_cnt + int'(m_done)) % 256;
        m_dwell = chg ? 0 : (tick ? ((m_dwell < 63) ? m_dwell + 1 : 63) : m_dwell);
        m_phase = np;
    endtask

    task automatic step(input logic [4:0] led, input logic tick, input logic clr,
                        input logic res);
        bus.LED     = led;
        bus.Tick    = tick;
        bus.Err_Clr = clr;
        Res         = res;
        @(posedge CLK_50MHz);
        m_step(res, led, tick, clr);
        #1;
    endtask

    task automatic hold(input logic [4:0] led, input int n);
        step(led, 1'b0, 1'b0, 1'b0);
        repeat (n) step(led, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(P_DARK, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(P_GREEN, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== 22'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 22'h0);
        end
    endtask

    task automatic test_normal_cycle();
        do_reset();
        hold(P_GREEN, 5);
        hold(P_YELLOW, 2);
        hold(P_RARROW, 2);
        hold(P_RED, 6);
        step(P_GREEN, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Time_Err, bus.Err_Code, bus.Cycle_Done, bus.Cycle_Cnt} !== {4'b0000, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL normal_cycle got=%b/%b/%0d/%b/%0d exp=0/0/0/1/1",
                     bus.Seq_Err, bus.Time_Err, bus.Err_Code, bus.Cycle_Done, bus.Cycle_Cnt);
        end
        step(P_GREEN, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== mdl_vec() || bus.Cycle_Done !== 1'b0) begin
            failures++;
            $display("FAIL normal_cycle_pulse got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_seq_error();
        do_reset();
        hold(P_GREEN, 3);
        step(P_RED, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Time_Err, bus.Err_Code, bus.Cycle_Cnt} !== {1'b1, 1'b0, 2'd1, 8'd0}) begin
            failures++;
            $display("FAIL seq_green_red got=%b/%b/%0d/%0d exp=1/0/1/0",
                     bus.Seq_Err, bus.Time_Err, bus.Err_Code, bus.Cycle_Cnt);
        end
        hold(P_RED, 2);
        step(P_GREEN, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.Cycle_Cnt !== 8'd1 || dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL seq_then_cycle got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_yellow_timing();
        do_reset();
        hold(P_GREEN, 3);
        hold(P_YELLOW, 1);
        step(P_RED, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Time_Err, bus.Err_Code} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL yellow_short got=%b/%b/%0d exp=0/1/2", bus.Seq_Err, bus.Time_Err, bus.Err_Code);
        end
        hold(P_RED, 2);
        hold(P_GREEN, 3);
        hold(P_YELLOW, 4);
        step(P_RARROW, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Time_Err, bus.Err_Code} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL yellow_long_keeps got=%b/%0d exp=1/2", bus.Time_Err, bus.Err_Code);
        end
        step(P_RARROW, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Time_Err, bus.Err_Code} !== 4'b0000) begin
            failures++;
            $display("FAIL err_clr got=%b/%b/%0d exp=0/0/0", bus.Seq_Err, bus.Time_Err, bus.Err_Code);
        end
        hold(P_RED, 1);
        hold(P_GREEN, 3);
        hold(P_YELLOW, 4);
        step(P_RED, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Time_Err, bus.Err_Code} !== {1'b1, 2'd3} || dut_vec() !== mdl_vec()) begin
            failures++;
            $display("FAIL yellow_long got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_red_stuck();
        do_reset();
        hold(P_GREEN, 3);
        hold(P_YELLOW, 2);
        hold(P_RED, 20);
        checks++;
        if ({bus.Time_Err, bus.Dwell} !== {1'b0, 6'd20}) begin
            failures++;
            $display("FAIL red_20 got=%b/%0d exp=0/20", bus.Time_Err, bus.Dwell);
        end
        step(P_RED, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.Time_Err, bus.Err_Code, bus.Dwell} !== {1'b1, 2'd3, 6'd21}) begin
            failures++;
            $display("FAIL red_21 got=%b/%0d/%0d exp=1/3/21", bus.Time_Err, bus.Err_Code, bus.Dwell);
        end
        step(P_RED, 1'b0, 1'b1, 1'b0);
        repeat (50) step(P_RED, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.Time_Err, bus.Err_Code, bus.Dwell} !== {1'b0, 2'd0, 6'd63}) begin
            failures++;
            $display("FAIL red_saturate got=%b/%0d/%0d exp=0/0/63", bus.Time_Err, bus.Err_Code, bus.Dwell);
        end
    endtask

    task automatic test_illegal_and_clr();
        do_reset();
        step(5'b11000, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Phase, bus.Seq_Err, bus.Err_Code} !== {3'd7, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL illegal got=%0d/%b/%0d exp=7/1/1", bus.Phase, bus.Seq_Err, bus.Err_Code);
        end
        step(P_DARK, 1'b0, 1'b0, 1'b0);
        hold(P_GREEN, 3);
        hold(P_YELLOW, 1);
        step(P_RED, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Time_Err, bus.Err_Code} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL clr_vs_new got=%b/%b/%0d exp=0/1/2", bus.Seq_Err, bus.Time_Err, bus.Err_Code);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(P_GREEN, 3);
        hold(P_YELLOW, 1);
        step(P_YELLOW, 1'b1, 1'b0, 1'b1);
        checks++;
        if (dut_vec() !== 22'h0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", dut_vec(), 22'h0);
        end
        hold(P_RED, 2);
        step(P_GREEN, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.Seq_Err, bus.Cycle_Done, bus.Cycle_Cnt} !== {1'b0, 1'b1, 8'd1}) begin
            failures++;
            $display("FAIL reset_then_cycle got=%b/%b/%0d exp=0/1/1",
                     bus.Seq_Err, bus.Cycle_Done, bus.Cycle_Cnt);
        end
    endtask

    function automatic logic [4:0] next_legal(input int ph);
        case (ph)
            1, 2:    return P_YELLOW;
            3:       return ($urandom_range(0, 1) != 0) ? P_RED : P_RARROW;
            4:       return ($urandom_range(0, 1) != 0) ? P_GREEN : P_ARROW;
            5:       return P_RED;
            default: return P_GREEN;
        endcase
    endfunction

    task automatic test_random();
        logic [4:0] led;
        logic tick, clr, res;
        int r, len;
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      led = 5'($urandom);
            else if (r == 1) led = P_DARK;
            else if (r == 2) led = next_legal(int'($urandom_range(0, 5)));
            else             led = next_legal(m_phase);
            len = (m_phase == 3 || led == P_YELLOW) ? int'($urandom_range(1, 5))
                                                    : int'($urandom_range(1, 8));
            if ($urandom_range(0, 30) == 0) len = 24;
            for (int k = 0; k <= len; k++) begin
                tick = (k != 0) && ($urandom_range(0, 3) != 0);
                clr  = ($urandom_range(0, 40) == 0);
                res  = ($urandom_range(0, 400) == 0);
                step(led, tick, clr, res);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++;
                    $display("FAIL random seg=%0d k=%0d got=%h exp=%h", seg, k, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        bus.LED     = P_DARK;
        bus.Tick    = 1'b0;
        bus.Err_Clr = 1'b0;
        test_reset();
        test_normal_cycle();
        test_seq_error();
        test_yellow_timing();
        test_red_stuck();
        test_illegal_and_clr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
